// File: rtl/hc16x_counter.sv
// hc16x_counter: parametrised up/down modulo counter with hc161-style CEP/CET/TC cascade controls,
// synchronous clear, parallel load and a registered wrap pulse.
module hc16x_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             CP,
    input  logic             MRN,
    input  logic             SRN,
    input  logic             PEN,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UDN,
    input  logic [WIDTH-1:0] Dn,
    output logic [WIDTH-1:0] Qn,
    output logic             TC,
    output logic             WRAP
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("hc16x_counter: WIDTH must be 2..16 and MODULUS 2..2**WIDTH");
    end

    // Out-of-range loaded values fall back into range on the next count step.
    always_comb begin
        q_nxt    = Qn;
        wrap_nxt = 1'b0;
        if (!SRN) begin
            q_nxt = '0;
        end else if (!PEN) begin
            q_nxt = Dn;
        end else if (CEP && CET) begin
            if (UDN) begin
                wrap_nxt = Qn >= TOP;
                q_nxt    = wrap_nxt ? '0 : Qn + 1'b1;
            end else begin
                wrap_nxt = Qn == '0;
                q_nxt    = (wrap_nxt || Qn > TOP) ? TOP : Qn - 1'b1;
            end
        end
    end

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            Qn   <= '0;
            WRAP <= 1'b0;
        end else begin
            Qn   <= q_nxt;
            WRAP <= wrap_nxt;
        end
    end

    assign TC = CET & (UDN ? Qn == TOP : Qn == '0);
endmodule
